cgol_gen_sequencer: RTL
=======================

// Module: cgol_gen_sequencer
// PURPOSE
//  Generation scheduler for the 8x8 Game of Life datapath. Sequences the two row register files:
//  - COMPUTE sweep: prev -> row decoder -> cur.
//  - COPY sweep: cur -> prev.
//  - DISPLAY hold for a programmable number of frames, with display row scan.
//  Adds run/step control and a valid/ready pattern-load port. Replaces the free-running address/count
//  controller; drives register-file write enables, the shared row address and the write-data mux select.
// PARAMETERS
//  ROWS            8    rows in grid; register files are ROWS deep
//  REGBITS         3    row address width, $clog2(ROWS)
//  FRAMES_PER_GEN  64   full display scans held per generation (>=1)
//  GEN_W           16   generation counter width
// PORTS
//  ph1         in   1        two-phase clock, phase 1; state advances at rising edge of ph1
//  ph2         in   1        two-phase clock, phase 2; master latch of every flop
//  reset       in   1        synchronous, active-low
//  run         in   1        level: 1 = advance generations continuously
//  step        in   1        advance exactly one generation; rising edge detected internally
//  load_valid  in   1        pattern-load request
//  load_row    in   REGBITS  row index of load data
//  load_ready  out  1        load accepted this cycle when load_valid & load_ready
//  addr        out  REGBITS  shared register-file row address (read and write)
//  cur_we      out  1        current-state register file write enable
//  prev_we     out  1        previous-state register file write enable
//  wd_sel      out  2        write data select: 0 = decoder next row, 1 = cur read data, 2 = load data
//  disp_addr   out  REGBITS  display row scan index
//  disp_en     out  1        1 = display valid; 0 blanks the LED rows
//  busy        out  1        1 in COMPUTE or COPY
//  gen_done    out  1        one-cycle pulse at the end of each generation's COPY sweep
//  gen_count   out  GEN_W    completed generations; wraps to 0 after all-ones
// BEHAVIOUR
//  - Reset (reset==0 at a ph1 edge):
//    - State goes to SEED; all counters and the step-pending flag clear.
//    - Outputs: addr=0, cur_we=0, prev_we=0, wd_sel=0, disp_addr=0, disp_en=0, busy=0,
//      gen_done=0, gen_count=0, load_ready=0.
//    - A reset mid-sweep abandons the sweep immediately; partially written rows are not restored.
//  - States: SEED, IDLE, COMPUTE, COPY, DISPLAY.
//  - SEED (ROWS cycles):
//    - Outputs: addr=k, wd_sel=1, prev_we=1, k=0..ROWS-1. Copies the cur preset pattern into prev.
//    - Transition: -> IDLE. No gen_done, no gen_count increment.
//  - IDLE:
//    - Outputs: disp_en=1, disp_addr increments every cycle (mod ROWS), load_ready=1.
//    - Load accepted (load_valid&load_ready): that cycle, addr=load_row, wd_sel=2, cur_we=1,
//      prev_we=1 (both files written).
//    - Load has priority. A step edge arriving in a load cycle sets step_pending; it is consumed on
//      the next cycle with no load.
//    - Transition: -> COMPUTE when run==1 or (step edge | step_pending) and no load is accepted.
//  - COMPUTE (ROWS cycles):
//    - Outputs: addr=k, wd_sel=0, cur_we=1, busy=1, disp_en=0.
//    - Transition: -> COPY.
//  - COPY (ROWS cycles):
//    - Outputs: addr=k, wd_sel=1, prev_we=1, busy=1, disp_en=0.
//    - On the last row: gen_done=1 and gen_count+1 (same edge).
//    - Transition: -> DISPLAY.
//  - DISPLAY (FRAMES_PER_GEN*ROWS cycles):
//    - Outputs: disp_en=1, disp_addr scans 0..ROWS-1 repeatedly.
//    - load_ready=0; step edges are ignored.
//    - Transition at the end of the last frame:
//      - -> COMPUTE if run==1.
//      - -> IDLE otherwise, with disp_addr continuing its scan.
//  - run deasserted mid-COMPUTE/COPY/DISPLAY: the current generation completes; the decision is
//    made only at the end of DISPLAY. step while run==1 has no effect.
//  - load_ready is 0 in every state except IDLE; load_valid outside IDLE waits (no drop, no error).
//  - Exactly one of cur_we/prev_we is high per COMPUTE/COPY cycle; both are high only on a load cycle.
//  - Row counter and frame counter wrap with explicit compare to ROWS-1 and FRAMES_PER_GEN-1;
//    no reliance on natural overflow.
//  - All outputs are registered (flop on ph2/ph1); no combinational input-to-output paths except
//    load_ready.
// STRUCTURE
//  - cgol_pkg:
//    - typedef enum logic [2:0] seq_state_t {SEED, IDLE, COMPUTE, COPY, DISPLAY}.
//    - typedef enum logic [1:0] wd_sel_t {WD_NEXT, WD_CUR, WD_LOAD}.
//    - localparams CGOL_ROWS and CGOL_REGBITS.
//  - Sub-module cgol_frame_timer:
//    - Row counter plus frame counter; outputs row index, last_row, last_frame.
//    - Inputs: clear, enable. Reused for the sweep and display counts.
//  - Top module: FSM, step edge detector with pending flag, gen counter, output registers.
// TESTING
//  - Reset then release:
//    - 8 cycles of prev_we=1, wd_sel=1, addr 0..7.
//    - Then IDLE with disp_en=1; gen_count=0; no gen_done.
//  - step pulse in IDLE, run=0:
//    - 8 COMPUTE cycles (cur_we=1, addr 0..7), then 8 COPY cycles.
//    - gen_done on addr=7 of COPY; gen_count=1; 512 DISPLAY cycles; back to IDLE.
//  - run=1 for 3 generations with the R-pentomino preset (rows 0-2 = 18h, 30h, 10h):
//    - gen_count=3; gen_done spaced exactly 528 cycles apart.
//    - Row outputs match a golden toroidal Life model.
//  - load_valid with load_row=5 and step edge in the same IDLE cycle:
//    - Load accepted (cur_we=prev_we=1, addr=5, wd_sel=2).
//    - COMPUTE starts the following cycle.
//  - load_valid held during DISPLAY:
//    - load_ready=0 throughout; the load completes on the first IDLE cycle.
//  - Corner cases:
//    - Reset asserted at COMPUTE row 4: next cycle in SEED with all outputs at reset values.
//    - gen_count wrap test with GEN_W=2: 3 -> 0.

Source files
------------

// File: rtl/cgol_pkg.sv
// Shared types and constants for the Game of Life generation sequencer.
//   seq_state_t : sequencer FSM states
//   wd_sel_t    : register-file write-data mux select
//   CGOL_ROWS / CGOL_REGBITS : default grid height and row address width
package cgol_pkg;

    localparam int CGOL_ROWS    = 8;
    localparam int CGOL_REGBITS = $clog2(CGOL_ROWS);

    typedef enum logic [2:0] {
        SEED,
        IDLE,
        COMPUTE,
        COPY,
        DISPLAY
    } seq_state_t;

    typedef enum logic [1:0] {
        WD_NEXT,
        WD_CUR,
        WD_LOAD
    } wd_sel_t;

endpackage

// File: rtl/cgol_gen_sequencer_if.sv
// Register-file and pattern-load port of the generation sequencer.
//   master (sequencer): drives addr, cur_we, prev_we, wd_sel, load_ready;
//                       receives load_valid, load_row.
//   slave (datapath / load source): the mirror image.
interface cgol_gen_sequencer_if #(
    parameter int REGBITS = cgol_pkg::CGOL_REGBITS
);
    import cgol_pkg::*;

    logic               load_valid;
    logic [REGBITS-1:0] load_row;
    logic               load_ready;
    logic [REGBITS-1:0] addr;
    logic               cur_we;
    logic               prev_we;
    wd_sel_t            wd_sel;

    modport master (
        input  load_valid, load_row,
        output load_ready, addr, cur_we, prev_we, wd_sel
    );

    modport slave (
        output load_valid, load_row,
        input  load_ready, addr, cur_we, prev_we, wd_sel
    );

endinterface

// File: rtl/cgol_frame_timer.sv
// Row counter with a frame counter behind it; times every sweep and the display hold.
//   ph1        : clock (state advances on rising edge)
//   clear      : synchronous clear of both counters, dominates enable
//   enable     : advance one row
//   row        : current row index 0..ROWS-1
//   last_row   : row == ROWS-1
//   last_frame : frame == FRAMES-1
module cgol_frame_timer #(
    parameter int ROWS    = 8,
    parameter int REGBITS = 3,
    parameter int FRAMES  = 64
) (
    input  logic               ph1,
    input  logic               clear,
    input  logic               enable,
    output logic [REGBITS-1:0] row,
    output logic               last_row,
    output logic               last_frame
);
    localparam int FBITS = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [FBITS-1:0] frame;

    assign last_row   = (row == REGBITS'(ROWS - 1));
    assign last_frame = (frame == FBITS'(FRAMES - 1));

    always_ff @(posedge ph1) begin
        if (clear) begin
            row   <= '0;
            frame <= '0;
        end else if (enable) begin
            if (last_row) begin
                row   <= '0;
                frame <= last_frame ? '0 : frame + FBITS'(1);
            end else begin
                row <= row + REGBITS'(1);
            end
        end
    end

endmodule

// File: rtl/cgol_gen_sequencer.sv
// Generation scheduler for the 8x8 Game of Life datapath.
//   ph1, ph2        : two-phase clock; flops update on the rising edge of ph1
//   reset           : synchronous, active-low
//   run, step       : continuous run level / single-generation request (edge detected)
//   bus (master)    : load handshake, shared row address, write enables, write-data select
//   disp_addr/en    : display row scan and LED row enable
//   busy            : COMPUTE or COPY in progress
//   gen_done        : one-cycle pulse at the last COPY row
//   gen_count       : completed generations, wraps
//
// state   | meaning
// SEED    | copy preset cur rows into prev, once after reset
// IDLE    | display scan, accept pattern loads, wait for run/step
// COMPUTE | sweep prev -> decoder -> cur
// COPY    | sweep cur -> prev, count the generation
// DISPLAY | hold FRAMES_PER_GEN full scans before the next decision
module cgol_gen_sequencer
    import cgol_pkg::*;
#(
    parameter int ROWS           = CGOL_ROWS,
    parameter int REGBITS        = CGOL_REGBITS,
    parameter int FRAMES_PER_GEN = 64,
    parameter int GEN_W          = 16
) (
    input  logic                ph1,
    input  logic                ph2,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    cgol_gen_sequencer_if.master bus,
    output logic [REGBITS-1:0]  disp_addr,
    output logic                disp_en,
    output logic                busy,
    output logic                gen_done,
    output logic [GEN_W-1:0]    gen_count
);
    // Flops are modelled edge-triggered on ph1; the ph2 master phase is implicit.
    logic unused_ph2;
    assign unused_ph2 = ph2;

    seq_state_t         state_q, state_d;
    logic               step_q, pending_q, pending_d;
    logic               step_edge, load_fire;
    logic               tmr_clear, tmr_clear_any;
    logic [REGBITS-1:0] row;
    logic               last_row, last_frame;

    logic [REGBITS-1:0] addr_d, disp_addr_d;
    logic               cur_we_d, prev_we_d, disp_en_d, busy_d, gen_done_d;
    wd_sel_t            wd_sel_d;

    assign bus.load_ready = (state_q == IDLE);
    assign load_fire      = bus.load_valid & bus.load_ready;
    assign step_edge      = step & ~step_q;
    assign tmr_clear_any  = tmr_clear | ~reset;

    cgol_frame_timer #(
        .ROWS    (ROWS),
        .REGBITS (REGBITS),
        .FRAMES  (FRAMES_PER_GEN)
    ) u_timer (
        .ph1        (ph1),
        .clear      (tmr_clear_any),
        .enable     (1'b1),
        .row        (row),
        .last_row   (last_row),
        .last_frame (last_frame)
    );

    always_ff @(posedge ph1) begin
        if (!reset) begin
            state_q   <= SEED;
            step_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step;
            pending_q <= pending_d;
        end
    end

    // Every state change restarts the timer, so each phase begins at row 0 / frame 0.
    // The IDLE scan simply continues from row 0 after SEED or DISPLAY.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        tmr_clear   = 1'b0;
        addr_d      = '0;
        cur_we_d    = 1'b0;
        prev_we_d   = 1'b0;
        wd_sel_d    = WD_NEXT;
        disp_addr_d = '0;
        disp_en_d   = 1'b0;
        busy_d      = 1'b0;
        gen_done_d  = 1'b0;
        case (state_q)
            SEED: begin
                addr_d    = row;
                wd_sel_d  = WD_CUR;
                prev_we_d = 1'b1;
                if (last_row) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end
            end
            IDLE: begin
                disp_en_d   = 1'b1;
                disp_addr_d = row;
                if (load_fire) begin
                    addr_d    = bus.load_row;
                    wd_sel_d  = WD_LOAD;
                    cur_we_d  = 1'b1;
                    prev_we_d = 1'b1;
                    if (step_edge) pending_d = 1'b1;
                end else if (run | step_edge | pending_q) begin
                    state_d   = COMPUTE;
                    pending_d = 1'b0;
                    tmr_clear = 1'b1;
                end
            end
            COMPUTE: begin
                addr_d   = row;
                wd_sel_d = WD_NEXT;
                cur_we_d = 1'b1;
                busy_d   = 1'b1;
                if (last_row) begin
                    state_d   = COPY;
                    tmr_clear = 1'b1;
                end
            end
            COPY: begin
                addr_d    = row;
                wd_sel_d  = WD_CUR;
                prev_we_d = 1'b1;
                busy_d    = 1'b1;
                if (last_row) begin
                    gen_done_d = 1'b1;
                    state_d    = DISPLAY;
                    tmr_clear  = 1'b1;
                end
            end
            DISPLAY: begin
                disp_en_d   = 1'b1;
                disp_addr_d = row;
                if (last_row && last_frame) begin
                    state_d   = run ? COMPUTE : IDLE;
                    tmr_clear = 1'b1;
                end
            end
            default: begin
                state_d   = SEED;
                tmr_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ph1) begin
        if (!reset) begin
            bus.addr    <= '0;
            bus.cur_we  <= 1'b0;
            bus.prev_we <= 1'b0;
            bus.wd_sel  <= WD_NEXT;
            disp_addr   <= '0;
            disp_en     <= 1'b0;
            busy        <= 1'b0;
            gen_done    <= 1'b0;
            gen_count   <= '0;
        end else begin
            bus.addr    <= addr_d;
            bus.cur_we  <= cur_we_d;
            bus.prev_we <= prev_we_d;
            bus.wd_sel  <= wd_sel_d;
            disp_addr   <= disp_addr_d;
            disp_en     <= disp_en_d;
            busy        <= busy_d;
            gen_done    <= gen_done_d;
            if (gen_done_d) gen_count <= gen_count + GEN_W'(1);
        end
    end

endmodule
